// File: rtl/moving_avg_fir_pkg.sv
// Shared types and elaboration helpers for the moving-average FIR and its delay line.
package moving_avg_pkg;

  typedef enum logic {
    FILL_EMPTY  = 1'b0,
    FILL_PRIMED = 1'b1
  } fill_state_e;

  // Exact log2 for power-of-two tap counts; gives shift amount and pointer width.
  function automatic int clog2_pow2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit taps_ok(input int n);
    return (n >= 2) && (n <= 256) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/moving_avg_fir_if.sv
// Sample stream into the filter and filtered stream out, one channel.
interface moving_avg_fir_if #(
  parameter int W = 24
);
  logic                in_valid;
  logic signed [W-1:0] data_in;
  logic                clear;
  logic                out_valid;
  logic signed [W-1:0] data_out;
  logic                primed;

  modport master (
    output in_valid, data_in, clear,
    input  out_valid, data_out, primed
  );

  modport slave (
    input  in_valid, data_in, clear,
    output out_valid, data_out, primed
  );
endinterface

// File: rtl/moving_avg_fir_delay_line.sv
// N-entry circular history of scaled samples; per-entry valid bits give a one-cycle flush.
module fir_delay_line
  import moving_avg_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic                clear,
  input  logic signed [W-1:0] wr_data,
  output logic signed [W-1:0] oldest
);
  localparam int PW = clog2_pow2(N);

  logic signed [W-1:0] mem [N];
  logic [N-1:0]        valid_reg;
  logic [PW-1:0]       wr_ptr_reg;

  // Read happens before the write at the same edge, so the slot being replaced is what leaves the sum.
  assign oldest = valid_reg[wr_ptr_reg] ? mem[wr_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_valid
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg[gi] <= 1'b0;
      end else if (clear) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_ptr_reg == PW'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/moving_avg_fir.sv
// Streaming N-tap moving average: pre-scaled samples feed a running sum updated once per sample.
module moving_avg_fir
  import moving_avg_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 24
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  moving_avg_fir_if.slave bus
);
  localparam int SHIFT = clog2_pow2(N);
  localparam logic [SHIFT:0] FILL_MAX  = (SHIFT + 1)'(N);
  localparam logic [SHIFT:0] FILL_LAST = (SHIFT + 1)'(N - 1);

  if (!taps_ok(N)) begin : g_bad_taps
    $error("moving_avg_fir: N must be a power of two in 2..256");
  end

  logic                accept;
  logic signed [W-1:0] scaled;
  logic signed [W-1:0] oldest;
  logic signed [W-1:0] acc_reg;
  logic [SHIFT:0]      fill_reg;
  fill_state_e         state_reg;
  logic                out_valid_reg;

  // Clear wins over a coincident sample.
  assign accept = bus.in_valid && !bus.clear;
  // Dividing before summing keeps the W-bit accumulator from overflowing.
  assign scaled = bus.data_in >>> SHIFT;

  fir_delay_line #(
    .N (N),
    .W (W)
  ) u_delay_line (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .wr_en   (accept),
    .clear   (bus.clear),
    .wr_data (scaled),
    .oldest  (oldest)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      fill_reg      <= '0;
      state_reg     <= FILL_EMPTY;
      out_valid_reg <= 1'b0;
    end else if (bus.clear) begin
      acc_reg       <= '0;
      fill_reg      <= '0;
      state_reg     <= FILL_EMPTY;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= accept;
      if (accept) begin
        acc_reg <= acc_reg + scaled - oldest;
        if (fill_reg != FILL_MAX) fill_reg <= fill_reg + 1'b1;
        if (fill_reg == FILL_LAST) state_reg <= FILL_PRIMED;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.data_out  = acc_reg;
  assign bus.primed    = (state_reg == FILL_PRIMED);

endmodule

// File: tb/tb_moving_avg_fir.sv
// Scoreboarded bench: driver pushes expected outputs from a sliding-window average model, monitor pops on out_valid.
module tb_moving_avg_fir;
  localparam int N = 16;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  moving_avg_fir_if #(.W(W)) bus ();

  moving_avg_fir #(.N(N), .W(W)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         primed;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   txn      = 0;

  always @(posedge clk) cyc++;

  function automatic int floor_div(input int x);
    int q;
    q = x / N;
    if (x < 0 && q * N != x) q = q - 1;
    return q;
  endfunction

  function automatic void check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void check_val(input string name, input logic [W-1:0] act, input int req);
    logic [W-1:0] r;
    r = req[W-1:0];
    checks++;
    if (act !== r) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, r);
    end
  endfunction

  // Model: output is the sum of floor(x/N) over the most recent N samples since reset/clear.
  function automatic void model_accept(input logic [W-1:0] v);
    int   sum;
    exp_t e;
    hist.push_front(int'($signed(v)));
    if (hist.size() > N) void'(hist.pop_back());
    sum = 0;
    foreach (hist[i]) sum += floor_div(hist[i]);
    e.data   = sum[W-1:0];
    e.primed = (hist.size() == N);
    e.cyc    = cyc + 1;
    sb.push_back(e);
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] x, input bit c);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.data_in  = x;
    bus.clear    = c;
    if (reset_n === 1'b1) begin
      if (c) hist.delete();
      else if (v) model_accept(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic burst(input int n, input logic [W-1:0] x);
    repeat (n) drive(1'b1, x, 1'b0);
  endtask

  task automatic drain(input string name);
    idle(3);
    check_int(name, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=%h required=none", bus.data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        txn++;
        $display("txn %0d: data_out=%0d primed=%b (exp %0d/%b)", txn, $signed(bus.data_out), bus.primed,
                 $signed(e.data), e.primed);
        check_val("data_out", bus.data_out, int'($signed(e.data)));
        check_int("primed", int'(bus.primed), int'(e.primed));
        check_int("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_data_out", bus.data_out, 0);
    check_int("reset_out_valid", int'(bus.out_valid), 0);
    check_int("reset_primed", int'(bus.primed), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Impulse: sixteen outputs of 100, then zeros.
    drive(1'b1, 24'd1600, 1'b0);
    burst(20, 24'd0);
    drain("impulse_drain");

    // Step: ramp to 1600, then hold.
    do_clear();
    burst(20, 24'd1600);
    drain("step_drain");
    check_val("step_hold", bus.data_out, 1600);
    check_int("step_primed", int'(bus.primed), 1);

    // Negative values and floor rounding.
    do_clear();
    burst(16, 24'hFFFFF0);
    drain("neg16_drain");
    check_val("neg16_final", bus.data_out, -16);
    do_clear();
    drive(1'b1, 24'hFFFFFF, 1'b0);
    burst(16, 24'd0);
    drain("neg1_drain");

    // Extremes.
    do_clear();
    burst(16, 24'h7FFFFF);
    drain("max_drain");
    check_val("max_final", bus.data_out, 24'h7FFFF0);
    do_clear();
    burst(16, 24'h800000);
    drain("min_drain");
    check_val("min_final", bus.data_out, 24'h800000);

    // Clear collides with a sample.
    do_clear();
    burst(16, 24'd1600);
    drive(1'b1, 24'd800, 1'b1);
    drive(1'b0, '0, 1'b0);
    check_val("clear_data_out", bus.data_out, 0);
    check_int("clear_primed", int'(bus.primed), 0);
    check_int("clear_out_valid", int'(bus.out_valid), 0);
    drive(1'b1, 24'd1600, 1'b0);
    drain("clear_drain");
    check_val("clear_restart", bus.data_out, 100);

    // Async reset between samples, not aligned to a clock edge.
    do_clear();
    burst(16, 24'd1600);
    idle(2);
    @(posedge clk);
    #3 reset_n = 1'b0;
    hist.delete();
    #1;
    check_val("async_data_out", bus.data_out, 0);
    check_int("async_primed", int'(bus.primed), 0);
    check_int("async_out_valid", int'(bus.out_valid), 0);
    drive(1'b1, 24'd500, 1'b0);
    drive(1'b0, '0, 1'b0);
    check_val("async_ignore", bus.data_out, 0);
    #3 reset_n = 1'b1;
    drive(1'b1, 24'd1600, 1'b0);
    drain("async_drain");
    check_val("async_restart", bus.data_out, 100);

    // Random traffic with occasional clears.
    do_clear();
    for (int i = 0; i < 400; i++) begin
      bit           v;
      bit           c;
      logic [31:0]  r;
      int           s;
      logic [W-1:0] x;
      v = ($urandom_range(0, 99) < 65);
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        x = r[W-1:0];
      end else begin
        s = int'($urandom_range(0, 4000)) - 2000;
        x = s[W-1:0];
      end
      drive(v, x, c);
    end
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
